// File: rtl/uart_rx_ext_if.sv
// Read-side bus of the UART receiver: strobe/cycle request, data and acknowledge.
interface uart_rx_ext_if;
    logic        stb_i;
    logic        cyc_i;
    logic [10:0] data_o;
    logic        ack_o;

    modport slave  (input  stb_i, input  cyc_i, output data_o, output ack_o);
    modport master (output stb_i, output cyc_i, input  data_o, input  ack_o);
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 5..8 data bits, optional parity, 1/2 stop bits,
// error/break flagging and a receive FIFO behind a stb/cyc/ack read port.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | line idle, waiting for a falling edge on the synchronised line
// S_START     | qualifying the start bit up to its midpoint (glitch filter)
// S_DATA      | sampling data bits LSB first, one per bit period
// S_PARITY    | sampling the parity bit
// S_STOP      | sampling the stop bit(s); result pushed the following cycle
// S_WAIT_IDLE | after a break, waiting for the line to return high
module uart_rx_ext #(
    parameter int CLKS_PER_BIT = 62,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_BITS    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    uart_rx_ext_if.slave         bus,
    output logic                 rx_ready_o,
    output logic [FIFO_BITS:0]   fifo_count_o,
    output logic                 overrun_o,
    input  logic                 clr_overrun_i,
    input  logic                 uart_rxd_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    localparam logic [15:0]        L_FULL      = 16'(CLKS_PER_BIT);
    localparam logic [15:0]        L_HALF      = 16'(CLKS_PER_BIT / 2);
    localparam logic [2:0]         L_LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic               L_LAST_STOP = (STOP_BITS == 2);
    localparam logic               L_ODD       = (PARITY == 1);
    localparam int                 L_DEPTH_I   = 2 ** FIFO_BITS;
    localparam logic [FIFO_BITS:0] L_DEPTH     = (FIFO_BITS + 1)'(L_DEPTH_I);

    // receiver registers and their next values
    logic [2:0]  r_sync;
    state_t      r_state,      w_state_nxt;
    logic [15:0] r_count,      w_count_nxt;
    logic [2:0]  r_bit_idx,    w_bit_idx_nxt;
    logic        r_stop_idx,   w_stop_idx_nxt;
    logic [7:0]  r_shift,      w_shift_nxt;
    logic        r_par_bit,    w_par_bit_nxt;
    logic        r_stop0,      w_stop0_nxt;
    logic        r_frm_err,    w_frm_err_nxt;
    logic        r_push,       w_push_nxt;
    logic [10:0] r_push_data,  w_push_data_nxt;

    // FIFO and read port
    logic [10:0]          r_mem [L_DEPTH_I];
    logic [FIFO_BITS-1:0] r_wr_ptr;
    logic [FIFO_BITS-1:0] r_rd_ptr;
    logic [FIFO_BITS:0]   r_fcount;
    logic                 r_ack_pend;
    logic                 r_overrun;
    logic [10:0]          r_data;

    logic w_rxd_s;
    logic w_par_err;
    logic w_frm_now;
    logic w_first_stop;
    logic w_is_break;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_ovr_set;

    assign w_rxd_s      = r_sync[2];
    assign w_par_err    = (PARITY != 0) && ((^r_shift ^ r_par_bit) != L_ODD);
    assign w_frm_now    = r_frm_err | ~w_rxd_s;
    assign w_first_stop = (r_stop_idx == 1'b0) ? w_rxd_s : r_stop0;
    assign w_is_break   = (r_shift == 8'h00) && ((PARITY == 0) || !r_par_bit) && !w_first_stop;

    // three-flop synchroniser for the asynchronous RX line; idles high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_sync <= 3'b111;
        else          r_sync <= {r_sync[1:0], uart_rxd_i};
    end

    // receiver state and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_stop_idx  <= 1'b0;
            r_shift     <= 8'h00;
            r_par_bit   <= 1'b0;
            r_stop0     <= 1'b1;
            r_frm_err   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 11'h000;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_stop_idx  <= w_stop_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_par_bit   <= w_par_bit_nxt;
            r_stop0     <= w_stop0_nxt;
            r_frm_err   <= w_frm_err_nxt;
            r_push      <= w_push_nxt;
            r_push_data <= w_push_data_nxt;
        end
    end

    // next-state and bit sampling; a break skips straight to waiting for idle
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_bit_idx_nxt   = r_bit_idx;
        w_stop_idx_nxt  = r_stop_idx;
        w_shift_nxt     = r_shift;
        w_par_bit_nxt   = r_par_bit;
        w_stop0_nxt     = r_stop0;
        w_frm_err_nxt   = r_frm_err;
        w_push_nxt      = 1'b0;
        w_push_data_nxt = r_push_data;
        case (r_state)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    w_count_nxt = 16'd1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == L_HALF) begin
                    w_count_nxt    = 16'd1;
                    w_bit_idx_nxt  = 3'd0;
                    w_stop_idx_nxt = 1'b0;
                    w_shift_nxt    = 8'h00;
                    w_par_bit_nxt  = 1'b0;
                    w_frm_err_nxt  = 1'b0;
                    w_state_nxt    = S_DATA;
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            S_DATA: begin
                if (r_count == L_FULL) begin
                    w_count_nxt = 16'd1;
                    w_shift_nxt[r_bit_idx] = w_rxd_s;
                    if (r_bit_idx == L_LAST_BIT) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            S_PARITY: begin
                if (r_count == L_FULL) begin
                    w_count_nxt   = 16'd1;
                    w_par_bit_nxt = w_rxd_s;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            S_STOP: begin
                if (r_count == L_FULL) begin
                    w_count_nxt   = 16'd1;
                    w_frm_err_nxt = w_frm_now;
                    if (r_stop_idx == 1'b0) w_stop0_nxt = w_rxd_s;
                    if (r_stop_idx == L_LAST_STOP) begin
                        w_push_nxt     = 1'b1;
                        w_stop_idx_nxt = 1'b0;
                        if (w_is_break) begin
                            w_push_data_nxt = {1'b1, 1'b0, 1'b1, r_shift};
                            w_state_nxt     = S_WAIT_IDLE;
                        end else begin
                            w_push_data_nxt = {1'b0, w_par_err, w_frm_now, r_shift};
                            w_state_nxt     = S_IDLE;
                        end
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxd_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // a full FIFO still accepts a push when a pop frees the slot in the same cycle
    assign w_pop     = bus.stb_i & bus.cyc_i & ~r_ack_pend & rx_ready_o;
    assign w_full    = (r_fcount == L_DEPTH);
    assign w_wr      = r_push & (~w_full | w_pop);
    assign w_ovr_set = r_push & w_full & ~w_pop;

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
    end

    // pointers, occupancy, read data, pending ack and sticky overrun
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fcount   <= '0;
            r_ack_pend <= 1'b0;
            r_overrun  <= 1'b0;
            r_data     <= 11'h000;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
            end
            if (w_wr && !w_pop)      r_fcount <= r_fcount + 1'b1;
            else if (w_pop && !w_wr) r_fcount <= r_fcount - 1'b1;
            if (w_pop)               r_ack_pend <= 1'b1;
            else if (!bus.stb_i)     r_ack_pend <= 1'b0;
            if (w_ovr_set)           r_overrun <= 1'b1;
            else if (clr_overrun_i)  r_overrun <= 1'b0;
        end
    end

    assign bus.data_o   = r_data;
    assign bus.ack_o    = r_ack_pend & bus.stb_i;
    assign rx_ready_o   = (r_fcount != '0);
    assign fifo_count_o = r_fcount;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: instance A is 8N1 with a 4-entry FIFO, instance B is
// 7 data bits, even parity, 2 stop bits. Expected entries go through queues.
module tb_uart_rx_ext;
    localparam int CPB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rxd_a, rxd_b, clr_a, clr_b;
    logic       rdy_a, rdy_b, ovr_a, ovr_b;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b;

    uart_rx_ext_if bus_a();
    uart_rx_ext_if bus_b();

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_BITS(2)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_a), .rx_ready_o(rdy_a), .fifo_count_o(cnt_a),
        .overrun_o(ovr_a), .clr_overrun_i(clr_a), .uart_rxd_i(rxd_a));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_BITS(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_b), .rx_ready_o(rdy_b), .fifo_count_o(cnt_b),
        .overrun_o(ovr_b), .clr_overrun_i(clr_b), .uart_rxd_i(rxd_b));

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] sb_a[$];
    logic [10:0] sb_b[$];

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst == 0) rxd_a = bits[i]; else rxd_b = bits[i];
            tick(CPB);
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        send_bits(0, {6'b111111, 1'b1, d, 1'b0}, 10);
        tick(2 * CPB);
    endtask

    task automatic set_bus(input int inst, input logic v);
        if (inst == 0) begin bus_a.stb_i = v; bus_a.cyc_i = v; end
        else           begin bus_b.stb_i = v; bus_b.cyc_i = v; end
    endtask

    function automatic logic get_ack(input int inst);
        return (inst == 0) ? bus_a.ack_o : bus_b.ack_o;
    endfunction

    function automatic logic [10:0] get_data(input int inst);
        return (inst == 0) ? bus_a.data_o : bus_b.data_o;
    endfunction

    // raise stb/cyc, wait (bounded) for ack; lat = cycles to ack, -1 on timeout
    task automatic do_read(input int inst, input int max_wait, output logic [10:0] d, output int lat);
        lat = -1;
        d = 11'h7FF;
        set_bus(inst, 1'b1);
        for (int i = 1; i <= max_wait; i++) begin
            @(posedge clk); #1;
            if (get_ack(inst)) begin lat = i; d = get_data(inst); break; end
        end
        set_bus(inst, 1'b0);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus_a.data_o !== 11'h000) begin n_err++; $display("FAIL reset_data_a: got %0h want 0", bus_a.data_o); end
        n_cmp++; if (bus_a.ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack_a: got %0b want 0", bus_a.ack_o); end
        n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL reset_ready_a: got %0b want 0", rdy_a); end
        n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL reset_count_a: got %0d want 0", cnt_a); end
        n_cmp++; if (ovr_a !== 1'b0) begin n_err++; $display("FAIL reset_overrun_a: got %0b want 0", ovr_a); end
        n_cmp++; if ({bus_b.data_o, rdy_b, cnt_b, ovr_b} !== 18'd0) begin n_err++; $display("FAIL reset_b: got %0h want 0", {bus_b.data_o, rdy_b, cnt_b, ovr_b}); end
    endtask

    task automatic test_8n1();
        logic [10:0] d, exp;
        int lat;
        send_a(8'hA5);
        sb_a.push_back(11'h0A5);
        n_cmp++; if (cnt_a !== 3'd1) begin n_err++; $display("FAIL 8n1_count: got %0d want 1", cnt_a); end
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL 8n1_ready: got %0b want 1", rdy_a); end
        do_read(0, 5, d, lat);
        exp = sb_a.pop_front();
        n_cmp++; if (d !== exp) begin n_err++; $display("FAIL 8n1_data: got %0h want %0h", d, exp); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL 8n1_latency: got %0d want 1", lat); end
        #1;
        n_cmp++; if (bus_a.ack_o !== 1'b0) begin n_err++; $display("FAIL 8n1_ack_drop: got %0b want 0", bus_a.ack_o); end
        tick(1);
        n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL 8n1_count_after: got %0d want 0", cnt_a); end
        n_cmp++; if (bus_a.data_o !== 11'h0A5) begin n_err++; $display("FAIL 8n1_data_hold: got %0h want a5", bus_a.data_o); end
    endtask

    task automatic test_parity_framing();
        logic [6:0] td [4] = '{7'h35, 7'h35, 7'h35, 7'h7F};
        logic       tp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       ts2[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [10:0] d, exp;
        logic pe, fe;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_bits(1, {5'h1F, ts2[i], 1'b1, tp[i], td[i], 1'b0}, 12);
            tick(2 * CPB);
            pe = ^{td[i], tp[i]};
            fe = ~ts2[i];
            sb_b.push_back({1'b0, pe, fe, 1'b0, td[i]});
        end
        n_cmp++; if (cnt_b !== 5'd4) begin n_err++; $display("FAIL par_count: got %0d want 4", cnt_b); end
        for (int i = 0; i < 4; i++) begin
            do_read(1, 5, d, lat);
            exp = sb_b.pop_front();
            n_cmp++; if (d !== exp) begin n_err++; $display("FAIL par_data%0d: got %0h want %0h", i, d, exp); end
            tick(1);
        end
    endtask

    task automatic test_break();
        logic [10:0] d, exp;
        int lat;
        rxd_a = 1'b0;
        tick(20 * CPB);
        n_cmp++; if (cnt_a !== 3'd1) begin n_err++; $display("FAIL break_count_low: got %0d want 1", cnt_a); end
        sb_a.push_back(11'h500);
        rxd_a = 1'b1;
        tick(3 * CPB);
        n_cmp++; if (cnt_a !== 3'd1) begin n_err++; $display("FAIL break_count_high: got %0d want 1", cnt_a); end
        send_a(8'h3C);
        sb_a.push_back(11'h03C);
        n_cmp++; if (cnt_a !== 3'd2) begin n_err++; $display("FAIL break_count_next: got %0d want 2", cnt_a); end
        for (int i = 0; i < 2; i++) begin
            do_read(0, 5, d, lat);
            exp = sb_a.pop_front();
            n_cmp++; if (d !== exp) begin n_err++; $display("FAIL break_data%0d: got %0h want %0h", i, d, exp); end
            tick(1);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [10:0] d, exp;
        int lat;
        for (int i = 0; i < 5; i++) begin
            send_a(vals[i]);
            if (i < 4) sb_a.push_back({3'b000, vals[i]});
        end
        n_cmp++; if (cnt_a !== 3'd4) begin n_err++; $display("FAIL ovr_count: got %0d want 4", cnt_a); end
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %0b want 1", ovr_a); end
        for (int i = 0; i < 4; i++) begin
            do_read(0, 5, d, lat);
            exp = sb_a.pop_front();
            n_cmp++; if (d !== exp) begin n_err++; $display("FAIL ovr_data%0d: got %0h want %0h", i, d, exp); end
            tick(1);
        end
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0b want 1", ovr_a); end
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b want 0", ovr_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h01, 8'h80, 8'hFE, 8'h6D};
        logic [10:0] d, exp;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_a(vals[i]);
            sb_a.push_back({3'b000, vals[i]});
        end
        n_cmp++; if (cnt_a !== 3'd4 || ovr_a !== 1'b0) begin n_err++; $display("FAIL b2b_full: got cnt %0d ovr %0b want 4 0", cnt_a, ovr_a); end
        // the stop sample lands 80 cycles after the start bit; the push follows one cycle later
        send_bits(0, {6'b111111, 1'b1, 8'h96, 1'b0}, 10);
        sb_a.push_back(11'h096);
        do_read(0, 5, d, lat);
        exp = sb_a.pop_front();
        n_cmp++; if (d !== exp) begin n_err++; $display("FAIL b2b_data: got %0h want %0h", d, exp); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL b2b_latency: got %0d want 1", lat); end
        tick(2 * CPB);
        n_cmp++; if (cnt_a !== 3'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", cnt_a); end
        n_cmp++; if (ovr_a !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %0b want 0", ovr_a); end
        for (int i = 0; i < 4; i++) begin
            do_read(0, 5, d, lat);
            exp = sb_a.pop_front();
            n_cmp++; if (d !== exp) begin n_err++; $display("FAIL b2b_drain%0d: got %0h want %0h", i, d, exp); end
            tick(1);
        end
    endtask

    task automatic test_empty_read();
        logic [10:0] d;
        int lat;
        fork
            do_read(0, 200, d, lat);
            send_bits(0, {6'b111111, 1'b1, 8'hC3, 1'b0}, 10);
        join
        n_cmp++; if (lat !== 82) begin n_err++; $display("FAIL empty_read_latency: got %0d want 82", lat); end
        n_cmp++; if (d !== 11'h0C3) begin n_err++; $display("FAIL empty_read_data: got %0h want c3", d); end
        tick(2 * CPB);
        n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL empty_read_count: got %0d want 0", cnt_a); end
    endtask

    task automatic test_glitch();
        rxd_a = 1'b0;
        tick(2);
        rxd_a = 1'b1;
        tick(4 * CPB);
        n_cmp++; if (cnt_a !== 3'd0 || rdy_a !== 1'b0) begin n_err++; $display("FAIL glitch: got cnt %0d rdy %0b want 0 0", cnt_a, rdy_a); end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] d, exp;
        int lat;
        send_a(8'h11);
        send_a(8'h22);
        do_read(0, 5, d, lat);
        tick(1);
        n_cmp++; if (d !== 11'h011 || cnt_a !== 3'd1) begin n_err++; $display("FAIL rst_pre: got %0h cnt %0d want 11 1", d, cnt_a); end
        send_bits(0, {6'b111111, 1'b1, 8'h5A, 1'b0}, 4);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_a.data_o !== 11'h000) begin n_err++; $display("FAIL rst_mid_data: got %0h want 0", bus_a.data_o); end
        n_cmp++; if ({rdy_a, cnt_a, ovr_a, bus_a.ack_o} !== 6'd0) begin n_err++; $display("FAIL rst_mid_status: got %0h want 0", {rdy_a, cnt_a, ovr_a, bus_a.ack_o}); end
        rxd_a = 1'b1;
        tick(3);
        rst_n = 1'b1;
        sb_a.delete();
        tick(2 * CPB);
        n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL rst_post_count: got %0d want 0", cnt_a); end
        send_a(8'h5A);
        sb_a.push_back(11'h05A);
        do_read(0, 5, d, lat);
        exp = sb_a.pop_front();
        n_cmp++; if (d !== exp) begin n_err++; $display("FAIL rst_post_data: got %0h want %0h", d, exp); end
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        set_bus(0, 1'b0);
        set_bus(1, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        test_reset();
        test_8n1();
        test_parity_framing();
        test_break();
        test_overrun();
        test_back_to_back();
        test_empty_read();
        test_glitch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–8 data bits, none/odd/even parity and 1 or 2 stop bits. Flags framing, parity, break and overrun errors, and buffers received characters in a fully usable FIFO. Sits on the peripheral bus behind the same stb/cyc/ack read handshake as the existing UART blocks.

Parameters:
CLKS_PER_BIT, 62, clk_i cycles per bit; must be ≥4.
DATA_BITS, 8, data bits per character; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_BITS, 4, FIFO depth is 2**FIFO_BITS entries, all entries usable.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  reset, asynchronous, active-low.
stb_i  in  1  read strobe.
cyc_i  in  1  bus cycle.
data_o  out  11  {break, parity_err, framing_err, char[7:0]}; char zero-extended above DATA_BITS.
ack_o  out  1  read acknowledge.
rx_ready_o  out  1  FIFO non-empty.
fifo_count_o  out  FIFO_BITS+1  number of entries held.
overrun_o  out  1  sticky: a character was dropped because the FIFO was full.
clr_overrun_i  in  1  one-cycle pulse that clears overrun_o.
uart_rxd_i  in  1  RX line, asynchronous input.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: data_o=0, ack_o=0, rx_ready_o=0, fifo_count_o=0, overrun_o=0. The FIFO is emptied, the state is IDLE, and all three synchroniser flops are set to 1.
- Reset mid-frame: the partial character is discarded. After reset releases, the receiver waits in IDLE for a new falling edge.
- Synchroniser: 3 flops; the synchronised line (rxd_s) lags uart_rxd_i by 3 cycles.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Bit counter is 16 bits wide.
- IDLE: on rxd_s=0, set count=1 and go to START.
- START:
  - If rxd_s returns to 1 before count==CLKS_PER_BIT/2, treat it as a glitch and return to IDLE.
  - At count==CLKS_PER_BIT/2 (mid start bit), reset count=1 and go to DATA.
- DATA:
  - Sample rxd_s each time count==CLKS_PER_BIT. Bits arrive LSB first into shift[bit_idx].
  - After DATA_BITS samples, go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY:
  - Sample one bit at count==CLKS_PER_BIT.
  - Parity error when (XOR of data bits XOR parity bit) != (PARITY==1 ? 1 : 0).
- STOP:
  - Sample STOP_BITS bits, one every CLKS_PER_BIT.
  - Framing error if any stop sample is 0.
- Break detection:
  - Break = all data bits 0, parity bit 0 (if present), and the first stop sample 0.
  - A break sets the break flag, clears parity_err and sets framing_err in the pushed entry, then goes to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s=1, then go to IDLE. After a non-break frame, STOP goes directly to IDLE on the last stop sample.
- Push:
  - The cycle after the last stop sample, {flags, char} is written to the FIFO.
  - Characters with errors are still pushed, with their flags set.
  - If the FIFO is full, the character is dropped and overrun_o is set. It stays set until clr_overrun_i.
  - If a set and clr_overrun_i occur in the same cycle, the set wins.
- Read handshake:
  - When stb_i&cyc_i&~ack_pend&rx_ready_o is true, on the next edge data_o is loaded from the FIFO head, the head pops, and ack_pend=1.
  - ack_o = ack_pend & stb_i (combinational), so ack_o drops in the same cycle stb_i drops.
  - ack_pend clears on the first edge where stb_i=0.
  - A read issued while the FIFO is empty waits with no ack until a character arrives; it is then acked 1 cycle after rx_ready_o rises.
  - data_o holds its value between reads.
- Simultaneous push and pop: both take effect in the same cycle, so fifo_count_o is unchanged.
  - When the FIFO is full and a pop occurs in the same cycle as a push, the push is accepted and no overrun occurs.
- Pointers: FIFO_BITS-bit pointers wrap modulo depth. A separate counter tracks occupancy, which ranges 0..2**FIFO_BITS.
- Latency: 1 cycle from stb_i (with FIFO non-empty) to ack_o.

Test Plan:
- CLKS_PER_BIT=8, 8N1: send 0xA5 -> one FIFO entry; read returns data_o=0x0A5, ack_o high 1 cycle after stb_i, fifo_count_o returns to 0.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: send 0x35 with a wrong parity bit -> data_o=0x235 (parity_err set). Send 0x35 with the second stop bit 0 -> data_o=0x135 (framing_err set).
- Break: hold the line low for 20 bit times -> exactly one entry data_o=0x500. No further pushes until the line returns high; the next character 0x3C reads back 0x03C.
- FIFO_BITS=2: send 5 characters without reading -> fifo_count_o=4 and overrun_o=1. Reads return the first 4 characters in order. A clr_overrun_i pulse clears overrun_o.
- FIFO holding 4 entries with a pop and a push in the same cycle -> fifo_count_o stays 4 and overrun_o stays 0. A stb_i issued on an empty FIFO stays unacked until a byte arrives.
- Glitch and reset: a 2-cycle low pulse on the line -> no entry. Asserting rst_n_i mid-frame -> all outputs go to 0 immediately; a clean 0x5A sent after reset is received correctly.
